// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//
// Owns the fetch PC and a single outstanding instruction-memory request using
// a grant/rvalid handshake. EX redirects override everything, and any response
// still in flight for the old path is dropped. A fetched instruction is held
// while decode is stalled. The IF/ID stall and flush controls are driven from
// here.
//
// Optional feature: define FETCH_PERF_EN to add the o_perf_fetched and
// o_perf_dropped counters. Core behaviour is the same with or without it.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   i_stall_d            decode hazard stall; the held instruction stays put
//   i_redirect           taken branch/jump from EX
//   i_redirect_pc        redirect target; bits [1:0] are forced to 0
//   o_imem_req           instruction memory request
//   o_imem_addr          request address (the fetch PC)
//   i_imem_gnt           request accepted this cycle
//   i_imem_rvalid        response data valid
//   i_imem_rdata         response instruction
//   o_pc, o_instr        pc/instr pair sent to IF/ID; instr is NOP when not valid
//   o_fetch_valid        pc/instr valid this cycle
//   o_stall_f, o_flush_f IF/ID stall and flush controls
//   o_perf_fetched       (FETCH_PERF_EN) count of instructions consumed
//   o_perf_dropped       (FETCH_PERF_EN) count of responses discarded by redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall_d,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_fetch_valid,
    output logic        o_stall_f,
`ifdef FETCH_PERF_EN
    output logic        o_flush_f,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_dropped
`else
    output logic        o_flush_f
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StValid,
        StDiscard
    } state_e;

    state_e      r_state,    w_state_d;
    logic [31:0] r_fetch_pc, w_fetch_pc_d;
    logic [31:0] r_pc,       w_pc_d;
    logic [31:0] r_instr,    w_instr_d;
    logic [31:0] w_redir_pc;
    logic        w_consume;
    logic        w_drop;

    assign w_redir_pc = {i_redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_fetch_pc <= RESET_PC;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
        end else begin
            r_state    <= w_state_d;
            r_fetch_pc <= w_fetch_pc_d;
            r_pc       <= w_pc_d;
            r_instr    <= w_instr_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_fetch_pc_d = r_fetch_pc;
        w_pc_d       = r_pc;
        w_instr_d    = r_instr;
        w_consume    = 1'b0;
        w_drop       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_redirect) w_fetch_pc_d = w_redir_pc;
                w_state_d = StReq;
            end
            StReq: begin
                // While the request is ungranted its address may still move.
                if (i_redirect) w_fetch_pc_d = w_redir_pc;
                if (i_imem_gnt) w_state_d = i_redirect ? StDiscard : StWait;
            end
            StWait: begin
                if (i_redirect) begin
                    w_fetch_pc_d = w_redir_pc;
                    w_drop       = i_imem_rvalid;
                    // The response may already be here; otherwise it must be drained.
                    w_state_d    = i_imem_rvalid ? StReq : StDiscard;
                end else if (i_imem_rvalid) begin
                    w_instr_d = i_imem_rdata;
                    w_pc_d    = r_fetch_pc;
                    w_state_d = StValid;
                end
            end
            StValid: begin
                if (i_redirect) begin
                    w_fetch_pc_d = w_redir_pc;
                    w_state_d    = StReq;
                end else if (!i_stall_d) begin
                    w_consume    = 1'b1;
                    w_fetch_pc_d = r_fetch_pc + 32'd4;
                    w_state_d    = StReq;
                end
            end
            StDiscard: begin
                if (i_redirect) w_fetch_pc_d = w_redir_pc;
                if (i_imem_rvalid) begin
                    w_drop    = 1'b1;
                    w_state_d = StReq;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_imem_req    = (r_state == StReq);
    assign o_imem_addr   = r_fetch_pc;
    assign o_fetch_valid = (r_state == StValid);
    assign o_pc          = r_pc;
    assign o_instr       = o_fetch_valid ? r_instr : NOP_INSTR;
    // A redirect always wins; without one a stalled IF/ID entry is never flushed.
    assign o_stall_f     = i_stall_d & ~i_redirect;
    assign o_flush_f     = i_redirect | (~o_fetch_valid & ~i_stall_d);

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= 32'd0;
            r_perf_dropped <= 32'd0;
        end else begin
            if (w_consume) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_drop)    r_perf_dropped <= r_perf_dropped + 32'd1;
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_dropped = r_perf_dropped;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_consume ^ w_drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with hand-computed expectations.
// A small memory responder lives inside tick(): whenever a request is granted
// at an edge, the next cycle returns rdata = 0x00500093 + addr. This can be
// turned off to create late or stray responses.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] DB  = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_stall_d, i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt, i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_pc, o_instr;
    logic        o_fetch_valid, o_stall_f, o_flush_f;
`ifdef FETCH_PERF_EN
    logic [31:0] o_perf_fetched, o_perf_dropped;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit auto_rsp = 1'b1;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .i_stall_d     (i_stall_d),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .o_fetch_valid (o_fetch_valid),
        .o_stall_f     (o_stall_f),
`ifdef FETCH_PERF_EN
        .o_flush_f     (o_flush_f),
        .o_perf_fetched(o_perf_fetched),
        .o_perf_dropped(o_perf_dropped)
`else
        .o_flush_f     (o_flush_f)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle; the responder answers a grant from this edge.
    task automatic tick();
        logic        granted;
        logic [31:0] gaddr;
        granted = o_imem_req & i_imem_gnt;
        gaddr   = o_imem_addr;
        @(posedge clk);
        #1;
        i_imem_rvalid = granted & auto_rsp;
        i_imem_rdata  = (granted & auto_rsp) ? DB + gaddr : 32'h0;
        #1;
    endtask

    task automatic check_valid(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, "_fv"},    {31'b0, o_fetch_valid}, 32'd1);
        check({tag, "_pc"},    o_pc, pc);
        check({tag, "_instr"}, o_instr, ins);
    endtask

    task automatic check_req(input string tag, input logic [31:0] addr);
        check({tag, "_req"},  {31'b0, o_imem_req}, 32'd1);
        check({tag, "_addr"}, o_imem_addr, addr);
        check({tag, "_fv"},   {31'b0, o_fetch_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; i_stall_d = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
        i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
        #2;
        // Reset values.
        check("rst_req",   {31'b0, o_imem_req}, 32'd0);
        check("rst_fv",    {31'b0, o_fetch_valid}, 32'd0);
        check("rst_pc",    o_pc, 32'h0);
        check("rst_instr", o_instr, NOP);
        check("rst_addr",  o_imem_addr, 32'h0);
        check("rst_flush", {31'b0, o_flush_f}, 32'd1);
        check("rst_stall", {31'b0, o_stall_f}, 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_pf", o_perf_fetched, 32'd0);
        check("rst_pd", o_perf_dropped, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // First fetch: IDLE -> REQ -> WAIT -> VALID.
        tick(); check_req("f0", 32'h0);
        tick(); check("f0_wait_fv", {31'b0, o_fetch_valid}, 32'd0);
        tick(); check_valid("f0", 32'h0, DB);
        tick(); check_req("f1", 32'h4);
        check("f1_pc_hold", o_pc, 32'h0);
        check("f1_nop", o_instr, NOP);
        tick(); tick(); check_valid("f1", 32'h4, DB + 32'h4);

        // Stall in VALID for 5 cycles.
        i_stall_d = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            check_valid("stl", 32'h4, DB + 32'h4);
            check("stl_sf",  {31'b0, o_stall_f}, 32'd1);
            check("stl_ff",  {31'b0, o_flush_f}, 32'd0);
            check("stl_req", {31'b0, o_imem_req}, 32'd0);
            tick();
        end
        i_stall_d = 1'b0;
        tick(); check_req("stl_next", 32'h8);

        // Redirect in WAIT before rvalid; the late response must be dropped.
        auto_rsp = 1'b0;
        tick();
        i_redirect = 1'b1; i_redirect_pc = 32'h100; #1;
        check("rw_ff", {31'b0, o_flush_f}, 32'd1);
        tick();
        i_redirect = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF; #1;
        check("rw_disc_req",   {31'b0, o_imem_req}, 32'd0);
        check("rw_disc_instr", o_instr, NOP);
        auto_rsp = 1'b1;
        tick(); check_req("rw_next", 32'h100);
        check("rw_instr", o_instr, NOP);
`ifdef FETCH_PERF_EN
        check("rw_pd", o_perf_dropped, 32'd1);
        check("rw_pf", o_perf_fetched, 32'd2);
`endif
        tick(); tick(); check_valid("rw_f", 32'h100, DB + 32'h100);

        // Redirect together with stall in VALID: redirect wins.
        i_stall_d = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h40; #1;
        check("rs_ff", {31'b0, o_flush_f}, 32'd1);
        check("rs_sf", {31'b0, o_stall_f}, 32'd0);
        tick();
        i_stall_d = 1'b0; i_redirect = 1'b0; #1;
        check_req("rs_next", 32'h40);

        // No grant for 4 cycles, then an unaligned redirect while ungranted.
        i_imem_gnt = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            check_req("ng", 32'h40);
            check("ng_ff", {31'b0, o_flush_f}, 32'd1);
            tick();
        end
        i_redirect = 1'b1; i_redirect_pc = 32'h203;
        tick();
        i_redirect = 1'b0; #1;
        check_req("ng_redir", 32'h200);
        i_imem_gnt = 1'b1;
        tick(); tick(); check_valid("ng_f", 32'h200, DB + 32'h200);

        // Reset while in WAIT, then stray responses in IDLE and REQ.
        tick(); check_req("rr_req", 32'h204);
        auto_rsp = 1'b0;
        tick();
        reset = 1'b1; #1;
        check("rr_req0",  {31'b0, o_imem_req}, 32'd0);
        check("rr_fv0",   {31'b0, o_fetch_valid}, 32'd0);
        check("rr_pc0",   o_pc, 32'h0);
        check("rr_instr", o_instr, NOP);
        check("rr_addr",  o_imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0000_0BAD;
        auto_rsp = 1'b1;
        tick();
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0000_0BAD; #1;
        check_req("rr_restart", 32'h0);
        tick(); check("rr_wait_instr", o_instr, NOP);
        tick(); check_valid("rr_f", 32'h0, DB);

        // Wrap-around of the fetch PC.
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFF;
        tick();
        i_redirect = 1'b0; #1;
        check_req("wr", 32'hFFFF_FFFC);
        tick(); tick(); check_valid("wr_f", 32'hFFFF_FFFC, DB + 32'hFFFF_FFFC);
        tick(); check_req("wr_next", 32'h0);

        // Redirect together with rvalid in WAIT: drop the data and refetch right away.
        tick();
        i_redirect = 1'b1; i_redirect_pc = 32'h300;
        tick();
        i_redirect = 1'b0; #1;
        check_req("wrv", 32'h300);
        check("wrv_instr", o_instr, NOP);
`ifdef FETCH_PERF_EN
        check("wrv_pd", o_perf_dropped, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
